// File: rtl/weight_fetch_if.sv
// Burst control, BRAM read port and weight output stream of weight_fetch.
// stall_cycles is present only when WEIGHT_FETCH_STALL_COUNT_EN is defined.
interface weight_fetch_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  start;
  logic [ADDR_WIDTH-1:0] base_addr;
  logic [ADDR_WIDTH:0]   count;
  logic                  busy;
  logic                  done;
  logic                  readEnable;
  logic [ADDR_WIDTH-1:0] readAddress;
  logic [DATA_WIDTH-1:0] readData;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_valid;
  logic                  out_ready;
`ifdef WEIGHT_FETCH_STALL_COUNT_EN
  logic [15:0]           stall_cycles;

  modport master (
    input  start, base_addr, count, readData, out_ready,
    output busy, done, readEnable, readAddress, out_data, out_valid, stall_cycles
  );
  modport slave (
    output start, base_addr, count, readData, out_ready,
    input  busy, done, readEnable, readAddress, out_data, out_valid, stall_cycles
  );
`else
  modport master (
    input  start, base_addr, count, readData, out_ready,
    output busy, done, readEnable, readAddress, out_data, out_valid
  );
  modport slave (
    output start, base_addr, count, readData, out_ready,
    input  busy, done, readEnable, readAddress, out_data, out_valid
  );
`endif
endinterface

// File: rtl/weight_fetch.sv
// Streams a burst of weight words from a registered-output BRAM through a 2-entry FIFO.
// Optional stall counter enabled by defining WEIGHT_FETCH_STALL_COUNT_EN.
module weight_fetch #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset_n,
  weight_fetch_if.master bus
);
  localparam int unsigned CW = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {IDLE = 2'd0, FETCH = 2'd1, DRAIN = 2'd2} state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_base;
  logic [CW-1:0]         r_count;
  logic [CW-1:0]         r_issued;
  logic                  r_inflight;
  logic                  r_zero_done;
  logic [DATA_WIDTH-1:0] r_mem [2];
  logic                  r_wr_ptr;
  logic                  r_rd_ptr;
  logic [1:0]            r_fill;

  logic                  w_start_ok;
  logic                  w_valid;
  logic                  w_pop;
  logic [1:0]            w_pending;
  logic                  w_read;
  logic                  w_last;

  assign w_start_ok = (r_state == IDLE) && bus.start;
  assign w_valid    = (r_fill != 2'd0);
  assign w_pop      = w_valid && bus.out_ready;
  // FIFO occupancy once this cycle's accepted word has left and the in-flight word has landed
  assign w_pending  = r_fill + 2'(r_inflight) - 2'(w_pop);

  always_comb begin
    w_state_nxt = r_state;
    w_read      = 1'b0;
    w_last      = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (bus.start && (bus.count != '0)) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_read = (r_issued != r_count) && (w_pending < 2'd2) && (r_fill != 2'd2);
        if (w_read && ((r_issued + CW'(1)) == r_count)) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_last = w_pop && (r_fill == 2'd1) && !r_inflight;
        if (w_last) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= IDLE;
      r_base      <= '0;
      r_count     <= '0;
      r_issued    <= '0;
      r_inflight  <= 1'b0;
      r_zero_done <= 1'b0;
      r_mem[0]    <= '0;
      r_mem[1]    <= '0;
      r_wr_ptr    <= 1'b0;
      r_rd_ptr    <= 1'b0;
      r_fill      <= 2'd0;
    end else begin
      r_state     <= w_state_nxt;
      r_zero_done <= w_start_ok && (bus.count == '0);
      if (w_start_ok && (bus.count != '0)) begin
        r_base   <= bus.base_addr;
        r_count  <= bus.count;
        r_issued <= '0;
      end else if (w_read) begin
        r_issued <= r_issued + CW'(1);
      end
      // BRAM data is valid only in the cycle after the read was issued
      r_inflight <= w_read;
      if (r_inflight) begin
        r_mem[r_wr_ptr] <= bus.readData;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) r_rd_ptr <= ~r_rd_ptr;
      r_fill <= r_fill + 2'(r_inflight) - 2'(w_pop);
    end
  end

  assign bus.busy        = (r_state != IDLE);
  assign bus.done        = r_zero_done || w_last;
  assign bus.readEnable  = w_read;
  assign bus.readAddress = w_read ? (r_base + r_issued[ADDR_WIDTH-1:0]) : '0;
  assign bus.out_valid   = w_valid;
  assign bus.out_data    = w_valid ? r_mem[r_rd_ptr] : '0;

`ifdef WEIGHT_FETCH_STALL_COUNT_EN
  logic [15:0] r_stall;

  // Saturating count of cycles the head word waits on downstream
  always_ff @(posedge clock) begin
    if (!reset_n || w_start_ok) begin
      r_stall <= '0;
    end else if (w_valid && !bus.out_ready && (r_stall != 16'hFFFF)) begin
      r_stall <= r_stall + 16'd1;
    end
  end

  assign bus.stall_cycles = r_stall;
`endif

endmodule

// File: tb/tb_weight_fetch.sv
// Directed bench for weight_fetch with a registered-output BRAM model.
// Stall counter checks compile in when WEIGHT_FETCH_STALL_COUNT_EN is defined.
module tb_weight_fetch;
  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;
  int   mon_buf = 0;
  int   mon_viol = 0;
  logic mon_re_prev = 1'b0;
  logic [31:0] mem [256];

  weight_fetch_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();

  weight_fetch #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clock   (clk),
    .reset_n (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  // BRAM: registered read data, zero when not reading
  always @(posedge clk) bus.readData <= bus.readEnable ? mem[bus.readAddress] : 32'h0;

  // Tracks FIFO occupancy from the pins to catch reads issued into a full buffer
  always @(posedge clk) begin
    if (!rst_n) begin
      mon_buf     = 0;
      mon_re_prev = 1'b0;
    end else begin
      if (bus.readEnable && (mon_buf >= 2)) mon_viol++;
      mon_buf     = mon_buf + int'(mon_re_prev) - int'(bus.out_valid && bus.out_ready);
      mon_re_prev = bus.readEnable;
    end
  end

  function automatic logic [31:0] f(input logic [7:0] a);
    return {8'hA5, a, ~a, a ^ 8'h3C};
  endfunction

  function automatic logic ready_at(input int mode, input int k);
    case (mode)
      1:       return (k % 3) == 0;
      2:       return !((k >= 2) && (k <= 4));
      default: return 1'b1;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic burst(input logic [7:0] base, input logic [8:0] cnt, input int mode);
    int   nre, nacc, first_v, viol0;
    bit   done_seen, prev_stall;
    logic exp_done;
    nre = 0; nacc = 0; first_v = -1; done_seen = 0; prev_stall = 0; viol0 = mon_viol;
    bus.base_addr = base;
    bus.count     = cnt;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; (k < 200) && !done_seen; k++) begin
      if (k > 0) tick();
      bus.out_ready = ready_at(mode, k);
      #1;
      if (bus.readEnable) begin
        chk("raddr", 64'(bus.readAddress), 64'(8'(base + 8'(nre))));
        nre++;
      end
      if (prev_stall) chk("hold_valid", 64'(bus.out_valid), 64'(1));
      if (bus.out_valid) begin
        if (first_v < 0) first_v = k;
        chk("data", 64'(bus.out_data), 64'(f(8'(base + 8'(nacc)))));
      end
      exp_done = bus.out_valid && bus.out_ready && (nacc == int'(cnt) - 1);
      chk("done", 64'(bus.done), 64'(exp_done));
      chk("busy", 64'(bus.busy), 64'(1));
      if (bus.out_valid && bus.out_ready) nacc++;
      if (bus.done) done_seen = 1;
      prev_stall = bus.out_valid && !bus.out_ready;
    end
    bus.out_ready = 1'b1;
    chk("done_seen", 64'(done_seen), 64'(1));
    chk("nread", 64'(nre), 64'(cnt));
    chk("nword", 64'(nacc), 64'(cnt));
    chk("latency", 64'(first_v), 64'(2));
    chk("rd_full_viol", 64'(mon_viol - viol0), 64'(0));
    tick();
    chk("idle_busy", 64'(bus.busy), 64'(0));
    chk("idle_valid", 64'(bus.out_valid), 64'(0));
    chk("idle_done", 64'(bus.done), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit found, saw_done;
    for (int a = 0; a < 256; a++) mem[a] = f(8'(a));
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.base_addr = '0;
    bus.count     = '0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_done", 64'(bus.done), 64'(0));
    chk("rst_re", 64'(bus.readEnable), 64'(0));
    chk("rst_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_addr", 64'(bus.readAddress), 64'(0));
    chk("rst_data", 64'(bus.out_data), 64'(0));
`ifdef WEIGHT_FETCH_STALL_COUNT_EN
    chk("rst_stall", 64'(bus.stall_cycles), 64'(0));
`endif
    rst_n = 1'b1;
    tick();

    // Straight burst, then a burst wrapping past the top address
    burst(8'h10, 9'd4, 0);
    burst(8'hFE, 9'd4, 0);
    // Downstream pattern 1,0,0 repeating
    burst(8'h30, 9'd8, 1);
    // Three-cycle stall after the first word appears
    burst(8'h20, 9'd4, 2);
`ifdef WEIGHT_FETCH_STALL_COUNT_EN
    chk("stall_cnt", 64'(bus.stall_cycles), 64'(3));
    tick();
    chk("stall_hold", 64'(bus.stall_cycles), 64'(3));
`endif

    // Zero-length burst
    bus.base_addr = 8'h55;
    bus.count     = 9'd0;
    bus.start     = 1'b1;
    #1;
    chk("z_re_start", 64'(bus.readEnable), 64'(0));
    tick();
    bus.start = 1'b0;
    chk("z_done", 64'(bus.done), 64'(1));
    chk("z_busy", 64'(bus.busy), 64'(0));
    chk("z_re", 64'(bus.readEnable), 64'(0));
    tick();
    chk("z_done_end", 64'(bus.done), 64'(0));
    chk("z_busy_end", 64'(bus.busy), 64'(0));
    chk("z_re_end", 64'(bus.readEnable), 64'(0));

    // Reset in the middle of a 16-word burst while the 5th word is presented
    bus.base_addr = 8'h40;
    bus.count     = 9'd16;
    bus.out_ready = 1'b1;
    bus.start     = 1'b1;
    tick();
    bus.start = 1'b0;
    found = 0;
    saw_done = 0;
    for (int k = 0; (k < 20) && !found; k++) begin
      tick();
      if (bus.done) saw_done = 1;
      if (bus.out_valid && (bus.out_data == f(8'h44))) found = 1;
    end
    chk("abort_reach_w5", 64'(found), 64'(1));
    chk("abort_no_done", 64'(saw_done), 64'(0));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("abort_busy", 64'(bus.busy), 64'(0));
    chk("abort_done", 64'(bus.done), 64'(0));
    chk("abort_re", 64'(bus.readEnable), 64'(0));
    chk("abort_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_addr", 64'(bus.readAddress), 64'(0));
    chk("abort_data", 64'(bus.out_data), 64'(0));
    tick();
    chk("abort_late_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_late_done", 64'(bus.done), 64'(0));
    chk("abort_late_busy", 64'(bus.busy), 64'(0));
    burst(8'h80, 9'd2, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/weight_fetch.md
WEIGHT_FETCH -- requirements
Module: weight_fetch

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, the weight word width (matches the BRAM data width).
REQ-002 The block SHALL have parameter ADDR_WIDTH, default 8, the BRAM address width.
REQ-003 The block SHALL have port clock, input, 1, the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, a synchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, a one-cycle request to begin a burst.
REQ-006 The block SHALL have port base_addr, input, ADDR_WIDTH, the first BRAM address of the burst.
REQ-007 The block SHALL have port count, input, ADDR_WIDTH+1, the number of words in the burst (0 to 2^ADDR_WIDTH).
REQ-008 The block SHALL have port busy, output, 1, high while a burst is in progress.
REQ-009 The block SHALL have port done, output, 1, a one-cycle pulse at burst completion.
REQ-010 The block SHALL have port readEnable, output, 1, the BRAM read enable.
REQ-011 The block SHALL have port readAddress, output, ADDR_WIDTH, the BRAM read address.
REQ-012 The block SHALL have port readData, input, DATA_WIDTH, the BRAM registered read data; it is valid exactly 1 cycle after readEnable and 0 otherwise.
REQ-013 The block SHALL have port out_data, output, DATA_WIDTH, the streamed weight.
REQ-014 The block SHALL have port out_valid, output, 1, high when out_data holds a word.
REQ-015 The block SHALL have port out_ready, input, 1, downstream acceptance; a transfer occurs when out_valid and out_ready are both high.

Function
REQ-016 The block SHALL implement FSM states IDLE, FETCH and DRAIN.
REQ-017 In IDLE, start with count>0 SHALL latch base_addr and count and enter FETCH on the next cycle; start with count==0 SHALL pulse done the next cycle, issue no reads, and remain in IDLE.
REQ-018 The block SHALL ignore start while busy is high.
REQ-019 In FETCH, the block SHALL assert readEnable only when (reads in flight + words buffered) < 2 and the issued-read count is below the latched count.
REQ-020 readAddress SHALL equal base_addr plus the issued-read count, modulo 2^ADDR_WIDTH (wraps from the top address to 0).
REQ-021 readData SHALL be captured into a 2-entry FIFO only in the cycle after a read was issued.
REQ-022 out_data and out_valid SHALL come from the FIFO head; order SHALL be preserved, with no word lost or duplicated under any out_ready pattern.
REQ-023 With out_ready held high, the block SHALL sustain 1 word per cycle, and the first out_valid SHALL occur 2 cycles after start.
REQ-024 When all reads have been issued, the FSM SHALL move FETCH->DRAIN.
REQ-025 In DRAIN, acceptance of the last word SHALL pulse done in that same cycle and return the FSM to IDLE.
REQ-026 busy SHALL be high in FETCH and DRAIN and low in IDLE.
REQ-027 out_data SHALL be held stable while out_valid is high and out_ready is low.

Reset
REQ-028 When reset_n is low at a clock edge, the block SHALL go to IDLE and clear the counters, the FIFO and the in-flight flag.
REQ-029 During and after reset, busy, done, readEnable, out_valid, readAddress and out_data SHALL all be 0.
REQ-030 A reset during a burst SHALL abort it without a done pulse and discard any read returning in the following cycle.

Configuration
REQ-031 When macro WEIGHT_FETCH_STALL_COUNT_EN is defined, the block SHALL add output stall_cycles, 16 bits, counting cycles with out_valid high and out_ready low; it saturates at 0xFFFF, clears on an accepted start and on reset, and holds after done.
REQ-032 When WEIGHT_FETCH_STALL_COUNT_EN is not defined, the stall_cycles port and its logic SHALL be absent, and all other behaviour SHALL be unchanged.

Verification
REQ-033 base_addr=0x10, count=4, out_ready=1 -> words from addresses 0x10 to 0x13 in order on 4 consecutive cycles, first word 2 cycles after start, done together with the 4th word.
REQ-034 base_addr=0xFE, count=4 -> reads of 0xFE, 0xFF, 0x00, 0x01; out_data matches the BRAM contents in that order.
REQ-035 count=8 with out_ready toggling 1,0,0,1,... -> all 8 words delivered exactly once in order, readEnable never issued with 2 words buffered, and out_data stable while stalled.
REQ-036 count=0 -> done high for exactly 1 cycle after start, readEnable never asserted, busy stays 0.
REQ-037 Start a count=16 burst, then assert reset_n=0 for 1 cycle at word 5 -> all outputs 0, no done pulse, and a following count=2 burst completes correctly.
REQ-038 With WEIGHT_FETCH_STALL_COUNT_EN defined, count=4 and out_ready low for 3 cycles -> stall_cycles=3 after done.
